// File: rtl/pe_buf_mgr.sv
// Buffer manager for one PE: loads the TBB, starts the PE, collects RBB writes, drains the RBB.
// Optional build macro PE_BUF_MGR_RBB_CLEAR_EN zeroes each RBB word as it is drained.
module pe_buf_mgr #(
    parameter int TBB_DATA_WIDTH = 32,
    parameter int TBB_ADDR_WIDTH = 10,
    parameter int RBB_DATA_WIDTH = 32,
    parameter int RBB_ADDR_WIDTH = 10
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      ld_valid,
    input  logic [TBB_DATA_WIDTH-1:0] ld_data,
    input  logic                      ld_last,
    output logic                      ld_ready,
    output logic                      bm2pe_start,
    input  logic                      pe2bm_done,
    input  logic [TBB_ADDR_WIDTH-1:0] pe2bm_tbbRdAddr,
    output logic [TBB_DATA_WIDTH-1:0] bm2pe_tbbRdDout,
    input  logic                      pe2bm_rbbWrEn,
    input  logic [RBB_ADDR_WIDTH-1:0] pe2bm_rbbWrAddr,
    input  logic [RBB_DATA_WIDTH-1:0] pe2bm_rbbWrDin,
    output logic                      dr_valid,
    output logic [RBB_DATA_WIDTH-1:0] dr_data,
    output logic                      dr_last,
    input  logic                      dr_ready,
    output logic                      ld_trunc,
    output logic [15:0]               job_cnt
);

    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [TBB_ADDR_WIDTH-1:0] TBB_MAX = '1;
    localparam logic [RBB_ADDR_WIDTH-1:0] RBB_MAX = '1;

    logic [TBB_DATA_WIDTH-1:0] r_tbb [0:(1<<TBB_ADDR_WIDTH)-1];
    logic [RBB_DATA_WIDTH-1:0] r_rbb [0:(1<<RBB_ADDR_WIDTH)-1];

    logic [1:0]                r_state;
    logic [TBB_ADDR_WIDTH-1:0] r_ld_ptr;
    logic [RBB_ADDR_WIDTH-1:0] r_dr_ptr;
    logic                      r_dr_valid;
    logic [RBB_DATA_WIDTH-1:0] r_dr_data;
    logic                      r_dr_last;
    logic [TBB_DATA_WIDTH-1:0] r_tbb_dout;
    logic                      r_ld_trunc;
    logic [15:0]               r_job_cnt;

    logic                      w_ld_fire;
    logic                      w_dr_fire;
    logic                      w_dr_load;
    logic                      w_rbb_we;
    logic [RBB_ADDR_WIDTH-1:0] w_rbb_waddr;
    logic [RBB_DATA_WIDTH-1:0] w_rbb_wdata;

    // ld_ready is gated by reset_n so no beat is accepted while reset is held.
    assign ld_ready    = reset_n && (r_state == S_LOAD);
    assign bm2pe_start = reset_n && (r_state == S_START);
    assign w_ld_fire   = ld_valid && ld_ready;
    assign w_dr_fire   = r_dr_valid && dr_ready;
    // Fetch the next drain word when the output register is empty or being consumed (not past the last).
    assign w_dr_load   = (r_state == S_DRAIN) && (!r_dr_valid || (dr_ready && !r_dr_last));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_rbb_we    = reset_n && (r_state == S_RUN) && pe2bm_rbbWrEn;
        w_rbb_waddr = pe2bm_rbbWrAddr;
        w_rbb_wdata = pe2bm_rbbWrDin;
`ifdef PE_BUF_MGR_RBB_CLEAR_EN
        // The presented word sits one address behind the fetch pointer.
        if (reset_n && (r_state == S_DRAIN) && w_dr_fire) begin
            w_rbb_we    = 1'b1;
            w_rbb_waddr = r_dr_ptr - 1'b1;
            w_rbb_wdata = '0;
        end
`endif
    end

    // NOTE: RAM arrays carry no reset; their contents survive reset_n by design.
    always_ff @(posedge clk) begin
        if (w_ld_fire)
            r_tbb[r_ld_ptr] <= ld_data;
        if (w_rbb_we)
            r_rbb[w_rbb_waddr] <= w_rbb_wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            r_tbb_dout <= '0;
        else
            r_tbb_dout <= r_tbb[pe2bm_tbbRdAddr];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_LOAD;
            r_ld_ptr   <= '0;
            r_dr_ptr   <= '0;
            r_dr_valid <= 1'b0;
            r_dr_data  <= '0;
            r_dr_last  <= 1'b0;
            r_ld_trunc <= 1'b0;
            r_job_cnt  <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_ld_fire) begin
                        r_ld_ptr <= r_ld_ptr + 1'b1;
                        if (ld_last || (r_ld_ptr == TBB_MAX)) begin
                            r_state  <= S_START;
                            r_ld_ptr <= '0;
                        end
                        if (!ld_last && (r_ld_ptr == TBB_MAX))
                            r_ld_trunc <= 1'b1;
                    end
                end
                S_START: r_state <= S_RUN;
                S_RUN: begin
                    if (pe2bm_done) begin
                        r_state  <= S_DRAIN;
                        r_dr_ptr <= '0;
                    end
                end
                default: begin
                    if (w_dr_load) begin
                        r_dr_valid <= 1'b1;
                        r_dr_data  <= r_rbb[r_dr_ptr];
                        r_dr_last  <= (r_dr_ptr == RBB_MAX);
                        r_dr_ptr   <= r_dr_ptr + 1'b1;
                    end else if (w_dr_fire) begin
                        r_dr_valid <= 1'b0;
                        r_dr_last  <= 1'b0;
                        r_dr_ptr   <= '0;
                        r_ld_ptr   <= '0;
                        r_job_cnt  <= r_job_cnt + 16'd1;
                        r_state    <= S_LOAD;
                    end
                end
            endcase
        end
    end

    assign bm2pe_tbbRdDout = r_tbb_dout;
    assign dr_valid        = r_dr_valid;
    assign dr_data         = r_dr_data;
    assign dr_last         = r_dr_last;
    assign ld_trunc        = r_ld_trunc;
    assign job_cnt         = r_job_cnt;

endmodule

// File: tb/tb_pe_buf_mgr.sv
// Directed self-checking bench for pe_buf_mgr with TBB depth 16 and RBB depth 8.
// Expected drain data depends on whether PE_BUF_MGR_RBB_CLEAR_EN is defined.
module tb_pe_buf_mgr;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        bm2pe_start;
    logic        pe2bm_done;
    logic [3:0]  pe2bm_tbbRdAddr;
    logic [31:0] bm2pe_tbbRdDout;
    logic        pe2bm_rbbWrEn;
    logic [2:0]  pe2bm_rbbWrAddr;
    logic [31:0] pe2bm_rbbWrDin;
    logic        dr_valid;
    logic [31:0] dr_data;
    logic        dr_last;
    logic        dr_ready;
    logic        ld_trunc;
    logic [15:0] job_cnt;

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] exp_q [8];

    always #5 clk = ~clk;

    pe_buf_mgr #(
        .TBB_DATA_WIDTH(32),
        .TBB_ADDR_WIDTH(4),
        .RBB_DATA_WIDTH(32),
        .RBB_ADDR_WIDTH(3)
    ) u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ld_valid       (ld_valid),
        .ld_data        (ld_data),
        .ld_last        (ld_last),
        .ld_ready       (ld_ready),
        .bm2pe_start    (bm2pe_start),
        .pe2bm_done     (pe2bm_done),
        .pe2bm_tbbRdAddr(pe2bm_tbbRdAddr),
        .bm2pe_tbbRdDout(bm2pe_tbbRdDout),
        .pe2bm_rbbWrEn  (pe2bm_rbbWrEn),
        .pe2bm_rbbWrAddr(pe2bm_rbbWrAddr),
        .pe2bm_rbbWrDin (pe2bm_rbbWrDin),
        .dr_valid       (dr_valid),
        .dr_data        (dr_data),
        .dr_last        (dr_last),
        .dr_ready       (dr_ready),
        .ld_trunc       (ld_trunc),
        .job_cnt        (job_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Advance to just after the next rising edge; inputs set afterwards are sampled at the following edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ld_ready"}, ld_ready, 0);
        check({tag, "_start"}, bm2pe_start, 0);
        check({tag, "_tbb_dout"}, bm2pe_tbbRdDout, 0);
        check({tag, "_dr_valid"}, dr_valid, 0);
        check({tag, "_dr_data"}, dr_data, 0);
        check({tag, "_dr_last"}, dr_last, 0);
        check({tag, "_ld_trunc"}, ld_trunc, 0);
        check({tag, "_job_cnt"}, job_cnt, 0);
    endtask

    // Load n words base+i; ld_last on the final one when with_last is set.
    task automatic load_words(input int n, input logic [31:0] base, input bit with_last);
        for (int i = 0; i < n; i++) begin
            ld_valid = 1'b1;
            ld_data  = base + i;
            ld_last  = with_last && (i == n - 1);
            check("load_ready", ld_ready, 1);
            check("load_no_start", bm2pe_start, 0);
            step();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    // Called in the first DRAIN cycle; consumes eight words and checks them against exp_q.
    task automatic drain(input bit toggle, input logic [15:0] exp_jobs);
        int          idx = 0;
        int          cyc = 0;
        bit          prev_stall = 0;
        logic [31:0] prev_data = '0;
        while (idx < 8 && cyc < 100) begin
            dr_ready = toggle ? (cyc % 3 == 1) : 1'b1;
            if (cyc == 0)
                check("dr_first_latency", dr_valid, 0);
            if (prev_stall) begin
                check("dr_stall_valid", dr_valid, 1);
                check("dr_stall_data", dr_data, prev_data);
            end
            if (dr_valid && dr_ready) begin
                check("dr_data", dr_data, exp_q[idx]);
                check("dr_last", dr_last, (idx == 7) ? 1 : 0);
                idx++;
            end
            prev_stall = dr_valid && !dr_ready;
            prev_data  = dr_data;
            step();
            cyc++;
        end
        dr_ready = 1'b0;
        check("dr_word_count", idx, 8);
        if (!toggle)
            check("dr_back_to_back", cyc, 9);
        check("dr_end_ld_ready", ld_ready, 1);
        check("dr_end_valid", dr_valid, 0);
        check("dr_end_job_cnt", job_cnt, exp_jobs);
    endtask

    initial begin
        reset_n         = 1'b0;
        ld_valid        = 1'b0;
        ld_data         = '0;
        ld_last         = 1'b0;
        pe2bm_done      = 1'b0;
        pe2bm_tbbRdAddr = '0;
        pe2bm_rbbWrEn   = 1'b0;
        pe2bm_rbbWrAddr = '0;
        pe2bm_rbbWrDin  = '0;
        dr_ready        = 1'b0;

        step();
        step();
        check_reset_outputs("rst");
        reset_n = 1'b1;
        step();
        check("post_rst_ld_ready", ld_ready, 1);

        // Job 1: five words, last on 0xA4.
        load_words(5, 32'hA0, 1'b1);
        check("j1_start_pulse", bm2pe_start, 1);
        check("j1_start_not_ready", ld_ready, 0);
        pe2bm_tbbRdAddr = 4'd3;
        step();
        check("j1_start_one_cycle", bm2pe_start, 0);
        check("j1_tbb_rd3", bm2pe_tbbRdDout, 32'hA3);
        check("j1_no_trunc", ld_trunc, 0);
        for (int k = 0; k < 8; k++) begin
            pe2bm_rbbWrEn   = 1'b1;
            pe2bm_rbbWrAddr = 3'(k);
            pe2bm_rbbWrDin  = 32'h100 + k;
            pe2bm_done      = (k == 7);
            step();
        end
        pe2bm_rbbWrEn = 1'b0;
        pe2bm_done    = 1'b0;
        for (int k = 0; k < 8; k++)
            exp_q[k] = 32'h100 + k;
        drain(1'b0, 16'd1);

        // Job 2: full TBB without ld_last, spurious writes/done in LOAD and DRAIN.
        pe2bm_rbbWrEn   = 1'b1;
        pe2bm_rbbWrAddr = 3'd0;
        pe2bm_rbbWrDin  = 32'hDEAD;
        pe2bm_done      = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'h200 + i;
            check("j2_load_ready", ld_ready, 1);
            check("j2_load_no_start", bm2pe_start, 0);
            if (i == 3)
                pe2bm_tbbRdAddr = 4'd3;
            if (i == 4)
                check("j2_rd_during_wr_old", bm2pe_tbbRdDout, 32'hA3);
            if (i == 5)
                check("j2_rd_after_wr_new", bm2pe_tbbRdDout, 32'h203);
            step();
        end
        ld_valid      = 1'b0;
        pe2bm_rbbWrEn = 1'b0;
        pe2bm_done    = 1'b0;
        check("j2_start_pulse", bm2pe_start, 1);
        check("j2_trunc_set", ld_trunc, 1);
        step();
        check("j2_run_not_ready", ld_ready, 0);
        check("j2_run_no_valid", dr_valid, 0);
        pe2bm_tbbRdAddr = 4'd15;
        pe2bm_done      = 1'b1;
        step();
        check("j2_tbb_rd15", bm2pe_tbbRdDout, 32'h20F);
        pe2bm_rbbWrEn   = 1'b1;
        pe2bm_rbbWrAddr = 3'd5;
        pe2bm_rbbWrDin  = 32'hBAD;
`ifdef PE_BUF_MGR_RBB_CLEAR_EN
        for (int k = 0; k < 8; k++)
            exp_q[k] = 32'h0;
`else
        for (int k = 0; k < 8; k++)
            exp_q[k] = 32'h100 + k;
`endif
        drain(1'b1, 16'd2);
        pe2bm_rbbWrEn = 1'b0;
        pe2bm_done    = 1'b0;
        check("j2_trunc_sticky", ld_trunc, 1);

        // Job 3: reset for one cycle in the middle of RUN.
        load_words(2, 32'h300, 1'b1);
        check("j3_start_pulse", bm2pe_start, 1);
        check("j3_trunc_still", ld_trunc, 1);
        step();
        pe2bm_rbbWrEn   = 1'b1;
        pe2bm_rbbWrAddr = 3'd2;
        pe2bm_rbbWrDin  = 32'h55;
        step();
        pe2bm_rbbWrEn = 1'b0;
        reset_n       = 1'b0;
        step();
        check_reset_outputs("midrun_rst");
        reset_n = 1'b1;
        step();
        check("reload_ready", ld_ready, 1);
        load_words(3, 32'h400, 1'b1);
        check("reload_start", bm2pe_start, 1);
        pe2bm_tbbRdAddr = 4'd0;
        step();
        check("reload_tbb_rd0", bm2pe_tbbRdDout, 32'h400);
        pe2bm_done = 1'b1;
        step();
        pe2bm_done = 1'b0;
`ifdef PE_BUF_MGR_RBB_CLEAR_EN
        for (int k = 0; k < 8; k++)
            exp_q[k] = 32'h0;
`else
        for (int k = 0; k < 8; k++)
            exp_q[k] = 32'h100 + k;
`endif
        exp_q[2] = 32'h55;
        drain(1'b0, 16'd1);
        check("reload_trunc_clear", ld_trunc, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
